// File: rtl/dma_sched_pkg.sv
// Shared definitions for the DMA request scheduler.
//   state_t   : scheduler FSM states
//   DEF_*     : default parameter values
//   clog2()   : width helper for the owner/pointer index
package dma_sched_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_LEN_W       = 23;
    localparam int unsigned DEF_TO_W        = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/dma_req_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index of the last grant; search starts at ptr+1 and wraps
//   grant   : index of the first set request found
//   any_req : at least one request is set
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant   = '0;
        cand    = '0;
        any_req = |req;
        // Scan from the farthest candidate back to ptr+1 so the nearest set bit is written last.
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (req[cand]) grant = cand;
        end
    end

endmodule

// File: rtl/dma_req_scheduler.sv
// Shares one DMA command channel between NUM_REQ requesters, one transfer at a time.
//   aclk, aresetn           : clock, asynchronous active-low reset
//   req_valid/addr/len      : per-requester request (packed slices), held until req_ack
//   req_ack/done/err        : one-cycle pulses back to the owning requester
//   cmd_valid/ready/addr/len: command handshake towards the DMA
//   dma_done, dma_err       : completion/error pulses from the DMA
//   dma_abort               : one-cycle pulse when the transfer times out
//   busy, owner, err_count  : status (err_count saturates at 8'hFF)
module dma_req_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned TO_W        = DEF_TO_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_err,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [ADDR_W-1:0]            cmd_addr,
    output logic [LEN_W-1:0]             cmd_len,
    input  logic                         dma_done,
    input  logic                         dma_err,
    output logic                         dma_abort,
    output logic                         busy,
    output logic [clog2(NUM_REQ)-1:0]    owner,
    output logic [7:0]                   err_count
);

    localparam int unsigned    OW      = clog2(NUM_REQ);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     grant;
    logic              any_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [TO_W-1:0]   to_cnt;
    logic              grant_en, fin_ok, fin_err, fin_abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    assign sel_addr = req_addr[32'(grant)*ADDR_W +: ADDR_W];
    assign sel_len  = req_len[32'(grant)*LEN_W +: LEN_W];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        fin_ok    = 1'b0;
        fin_err   = 1'b0;
        fin_abort = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_en  = 1'b1;
                    state_nxt = (sel_len == '0) ? ZERO : ISSUE;
                end
            end
            ZERO: begin
                fin_err   = 1'b1;
                state_nxt = IDLE;
            end
            ISSUE: begin
                // cmd_valid is always high in ISSUE, so cmd_ready alone completes the handshake.
                if (cmd_ready) state_nxt = WAIT;
            end
            WAIT: begin
                // DMA events take priority over a timeout landing in the same cycle.
                if (dma_err) begin
                    fin_err   = 1'b1;
                    state_nxt = DONE;
                end else if (dma_done) begin
                    fin_ok    = 1'b1;
                    state_nxt = DONE;
                end else if (to_cnt == TO_LAST) begin
                    fin_abort = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr       <= OW'(NUM_REQ - 1);
            owner     <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            req_ack   <= '0;
            req_done  <= '0;
            req_err   <= '0;
            dma_abort <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
            to_cnt    <= '0;
        end else begin
            req_ack   <= '0;
            req_done  <= '0;
            req_err   <= '0;
            dma_abort <= fin_abort;
            busy      <= (state_nxt != IDLE);
            cmd_valid <= (state_nxt == ISSUE);
            to_cnt    <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            if (grant_en) begin
                ptr            <= grant;
                owner          <= grant;
                cmd_addr       <= sel_addr;
                cmd_len        <= sel_len;
                req_ack[grant] <= 1'b1;
            end
            if (fin_ok) req_done[owner] <= 1'b1;
            if (fin_err || fin_abort) begin
                req_err[owner] <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dma_req_scheduler.sv
module tb_dma_req_scheduler;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 23;
    localparam int TO = 40;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_TMO  = 3;
    localparam int K_LATE = 4;

    logic              aclk;
    logic              aresetn;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ack, req_done, req_err;
    logic              cmd_valid, cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic [LW-1:0]     cmd_len;
    logic              dma_done, dma_err, dma_abort, busy;
    logic [1:0]        owner;
    logic [7:0]        err_count;

    dma_req_scheduler #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .LEN_W       (LW),
        .TO_W        (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .req_err   (req_err),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .dma_abort (dma_abort),
        .busy      (busy),
        .owner     (owner),
        .err_count (err_count)
    );

    typedef struct { int idx; bit is_err; bit abort; int errcnt; } fin_t;
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; } cmd_t;
    typedef struct { int kind; int rdelay; int ddelay; } beh_t;

    int   exp_ack_q[$];
    cmd_t exp_cmd_q[$];
    fin_t exp_fin_q[$];
    beh_t beh_q[$];

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   hs_cyc = 0;
    bit   cmd_seen = 0;
    bit   stuck = 0;
    cmd_t cur_cmd;
    int   m_ptr = NR - 1;
    int   exp_err = 0;

    logic [AW-1:0] r_addr [NR];
    logic [LW-1:0] r_len  [NR];
    int            r_kind [NR];
    int            r_rd   [NR];
    int            r_dd   [NR];

    // monitor scratch
    int            m_e;
    fin_t          m_f;
    logic [NR-1:0] m_oh, m_xd, m_xe;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_addr"},  cmd_addr,  0);
        chk({tag, "_cmd_len"},   cmd_len,   0);
        chk({tag, "_req_ack"},   req_ack,   0);
        chk({tag, "_req_done"},  req_done,  0);
        chk({tag, "_req_err"},   req_err,   0);
        chk({tag, "_dma_abort"}, dma_abort, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_owner"},     owner,     0);
        chk({tag, "_err_count"}, err_count, 0);
    endtask

    // Requesters drop their request once acknowledged.
    initial forever begin
        @(negedge aclk);
        if (aresetn) req_valid = req_valid & ~req_ack;
    end

    // DMA model: optional ready back-pressure (with a stray done pulse while
    // the command is still pending), then the planned completion behaviour.
    initial begin
        beh_t b;
        cmd_ready = 1'b0;
        dma_done  = 1'b0;
        dma_err   = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (aresetn && cmd_valid && beh_q.size() > 0) begin
                b = beh_q.pop_front();
                for (int k = 0; k < b.rdelay; k++) begin
                    if (k == 0) dma_done = 1'b1;
                    @(posedge aclk); #1;
                    dma_done = 1'b0;
                end
                cmd_ready = 1'b1;
                @(posedge aclk); #1;
                cmd_ready = 1'b0;
                for (int k = 0; k < b.ddelay; k++) begin
                    @(posedge aclk); #1;
                end
                case (b.kind)
                    K_DONE, K_LATE: dma_done = 1'b1;
                    K_ERR:          dma_err  = 1'b1;
                    K_BOTH: begin
                        dma_done = 1'b1;
                        dma_err  = 1'b1;
                    end
                    default: ;
                endcase
                @(posedge aclk); #1;
                dma_done = 1'b0;
                dma_err  = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge aclk);
        if (aresetn) begin
            if (req_ack != '0) begin
                chk("ack_onehot", $countones(req_ack), 1);
                if (exp_ack_q.size() == 0) chk("unexpected_ack", req_ack, 0);
                else begin
                    m_e = exp_ack_q.pop_front();
                    m_oh = '0;
                    m_oh[m_e] = 1'b1;
                    chk("ack_idx", req_ack, m_oh);
                    chk("owner", owner, m_e);
                end
            end
            if (cmd_valid) begin
                if (!cmd_seen) begin
                    if (exp_cmd_q.size() == 0) chk("unexpected_cmd", cmd_valid, 0);
                    else begin
                        cur_cmd = exp_cmd_q.pop_front();
                        chk("cmd_addr", cmd_addr, cur_cmd.addr);
                        chk("cmd_len",  cmd_len,  cur_cmd.len);
                    end
                    cmd_seen = 1'b1;
                end else begin
                    chk("cmd_addr_stable", cmd_addr, cur_cmd.addr);
                    chk("cmd_len_stable",  cmd_len,  cur_cmd.len);
                end
                if (cmd_ready) begin
                    hs_cyc   = cyc + 1;
                    cmd_seen = 1'b0;
                end
            end
            if ((req_done | req_err) != '0) begin
                chk("fin_onehot", $countones({req_done, req_err}), 1);
                if (exp_fin_q.size() == 0) begin
                    chk("unexpected_done", req_done, 0);
                    chk("unexpected_err",  req_err,  0);
                end else begin
                    m_f = exp_fin_q.pop_front();
                    m_oh = '0;
                    m_oh[m_f.idx] = 1'b1;
                    m_xd = m_f.is_err ? '0 : m_oh;
                    m_xe = m_f.is_err ? m_oh : '0;
                    chk("req_done", req_done, m_xd);
                    chk("req_err",  req_err,  m_xe);
                    chk("dma_abort", dma_abort, m_f.abort);
                    chk("err_count", err_count, m_f.errcnt);
                    if (m_f.abort) chk("timeout_latency", cyc - hs_cyc, TO);
                end
            end else if (dma_abort) begin
                chk("stray_abort", dma_abort, 0);
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input int kind, input int rd, input int dd);
        r_addr[i] = a;
        r_len[i]  = l;
        r_kind[i] = kind;
        r_rd[i]   = rd;
        r_dd[i]   = dd;
    endtask

    task automatic randomize_req(input int i);
        int r;
        r = int'($urandom_range(0, 9));
        r_addr[i] = $urandom;
        r_len[i]  = ($urandom_range(0, 5) == 0) ? '0 : LW'($urandom_range(1, 23'h7FFFFF));
        r_kind[i] = (r < 5) ? K_DONE : (r < 7) ? K_ERR : (r == 7) ? K_BOTH : (r == 8) ? K_TMO : K_LATE;
        r_rd[i]   = int'($urandom_range(0, 3));
        r_dd[i]   = (r_kind[i] == K_LATE) ? TO : int'($urandom_range(0, 12));
    endtask

    // Expected service order: requests are held until acked and all are raised
    // together, so the order is round-robin over the set, starting after the last grant.
    task automatic plan(input logic [NR-1:0] mask);
        logic [NR-1:0] pend;
        int   pick;
        fin_t f;
        cmd_t c;
        beh_t b;
        pend = mask;
        while (pend != '0) begin
            pick = -1;
            for (int k = 1; k <= NR; k++)
                if (pick < 0 && pend[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
            pend[pick] = 1'b0;
            m_ptr = pick;
            exp_ack_q.push_back(pick);
            f.idx = pick;
            f.abort = 1'b0;
            if (r_len[pick] == '0) begin
                f.is_err = 1'b1;
            end else begin
                c.addr = r_addr[pick];
                c.len  = r_len[pick];
                exp_cmd_q.push_back(c);
                b.kind   = r_kind[pick];
                b.rdelay = r_rd[pick];
                b.ddelay = r_dd[pick];
                beh_q.push_back(b);
                f.is_err = (r_kind[pick] != K_DONE);
                f.abort  = (r_kind[pick] == K_TMO) || (r_kind[pick] == K_LATE);
            end
            if (f.is_err && exp_err < 255) exp_err++;
            f.errcnt = exp_err;
            exp_fin_q.push_back(f);
        end
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = r_addr[i];
            req_len[i*LW +: LW]  = r_len[i];
        end
    endtask

    task automatic flush();
        exp_ack_q.delete();
        exp_cmd_q.delete();
        exp_fin_q.delete();
        beh_q.delete();
        cmd_seen  = 1'b0;
        req_valid = '0;
    endtask

    task automatic run_round(input logic [NR-1:0] mask);
        if (stuck) return;
        plan(mask);
        @(posedge aclk); #1;
        req_valid = mask;
        for (int n = 0; n < 3000 && (exp_fin_q.size() != 0 || exp_ack_q.size() != 0); n++)
            @(posedge aclk);
        if (exp_fin_q.size() != 0 || exp_ack_q.size() != 0) begin
            chk("round_complete_pending", exp_fin_q.size() + exp_ack_q.size(), 0);
            stuck = 1'b1;
            flush();
            return;
        end
        repeat (2) @(posedge aclk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_err_count", err_count, exp_err);
    endtask

    initial begin
        int hs_old;
        aresetn   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk_all_zero("por");
        @(negedge aclk);
        aresetn = 1'b1;

        // Single request on requester 2.
        set_req(2, 32'h8000_0000, 23'h400, K_DONE, 0, 10);
        run_round(4'b0100);

        // All four requesters, two full rotations.
        for (int i = 0; i < NR; i++) set_req(i, $urandom, LW'($urandom_range(1, 4096)), K_DONE, 0, 2);
        run_round(4'b1111);
        run_round(4'b1111);

        // Back-pressure: cmd_ready low for 5 cycles.
        set_req(3, 32'h1234_5678, 23'h7FFFFF, K_DONE, 5, 3);
        run_round(4'b1000);

        // No completion: timeout abort.
        set_req(0, 32'hDEAD_BEEF, 23'h10, K_TMO, 0, 0);
        run_round(4'b0001);

        // Zero-length request.
        set_req(1, 32'h0000_1000, 23'h0, K_DONE, 0, 0);
        run_round(4'b0010);

        // Done and error together.
        set_req(2, 32'hA5A5_0000, 23'h20, K_BOTH, 1, 4);
        run_round(4'b0100);

        // Completion on the last cycle before timeout, and one cycle too late.
        set_req(0, 32'h0000_0040, 23'h40, K_DONE, 0, TO - 1);
        run_round(4'b0001);
        set_req(1, 32'h0000_0080, 23'h80, K_ERR, 0, TO - 1);
        run_round(4'b0010);
        set_req(3, 32'h0000_00C0, 23'hC0, K_LATE, 0, TO);
        run_round(4'b1000);

        // DMA pulses while idle must be ignored.
        @(posedge aclk); #1;
        dma_done = 1'b1;
        dma_err  = 1'b1;
        @(posedge aclk); #1;
        dma_done = 1'b0;
        dma_err  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("idle_pulse_busy", busy, 0);
        chk("idle_pulse_err_count", err_count, exp_err);

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NR; i++) randomize_req(i);
            run_round(NR'($urandom_range(1, 15)));
        end

        // Reset while waiting for completion.
        if (!stuck) begin
            set_req(1, 32'h5555_0000, 23'h100, K_TMO, 0, 0);
            plan(4'b0010);
            @(posedge aclk); #1;
            req_valid = 4'b0010;
            hs_old = hs_cyc;
            for (int n = 0; n < 200 && hs_cyc == hs_old; n++) @(posedge aclk);
            if (hs_cyc == hs_old) chk("reset_test_handshake_seen", 0, 1);
            repeat (5) @(posedge aclk);
            #1;
            aresetn = 1'b0;
            #1;
            chk_all_zero("mid_reset");
            flush();
            m_ptr   = NR - 1;
            exp_err = 0;
            @(negedge aclk);
            aresetn = 1'b1;
            for (int i = 0; i < NR; i++) set_req(i, $urandom, LW'($urandom_range(1, 255)), K_DONE, 0, 1);
            run_round(4'b1111);
        end

        // Drive the error counter into saturation.
        for (int r = 0; r < 120 && exp_err < 255; r++) begin
            for (int i = 0; i < NR; i++) set_req(i, $urandom, LW'($urandom_range(1, 255)), K_ERR, 0, 0);
            run_round(4'b1111);
        end
        for (int i = 0; i < NR; i++) set_req(i, $urandom, 23'h0, K_ERR, 0, 0);
        run_round(4'b0011);
        for (int i = 0; i < NR; i++) set_req(i, $urandom, LW'($urandom_range(1, 255)), K_TMO, 0, 0);
        run_round(4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dma_req_scheduler.md
Name: dma_req_scheduler

Overview:
- Shares the single DMA MM2S/S2MM command channel in the MicroBlaze/DMA block design between NUM_REQ hardware requesters.
- Round-robin arbitration; exactly one transfer outstanding at a time.
- Latches the winner's address and length, issues one command with a valid/ready handshake, then waits for DMA completion, error or timeout.
- Routes per-requester done/error pulses back to the owner and keeps a saturating error counter for status/LED logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, DMA buffer address width.
- LEN_W, 23, transfer length width in bytes (matches the DMA length register).
- TO_W, 16, timeout counter width.
- TIMEOUT_CYC, 16'hFFFF, cycles allowed in WAIT before abort (must fit TO_W).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ack.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, slice i for requester i.
- req_len  in  NUM_REQ*LEN_W  packed lengths.
- req_ack  out  NUM_REQ  one-cycle pulse: request accepted and fields captured.
- req_done  out  NUM_REQ  one-cycle pulse: owner's transfer completed OK.
- req_err  out  NUM_REQ  one-cycle pulse: owner's transfer failed, timed out, or had zero length.
- cmd_valid  out  1  command valid to the DMA.
- cmd_ready  in  1  DMA accepts the command.
- cmd_addr  out  ADDR_W  command address.
- cmd_len  out  LEN_W  command length.
- dma_done  in  1  completion pulse from the DMA.
- dma_err  in  1  error pulse from the DMA.
- dma_abort  out  1  one-cycle pulse on timeout (drives DMA soft reset).
- busy  out  1  high in any state other than IDLE.
- owner  out  clog2(NUM_REQ)  index of the current or last grant.
- err_count  out  8  saturating count of failed transfers.

Behaviour:
- Reset (async, aresetn=0): state=IDLE. All outputs are 0: cmd_valid, cmd_addr, cmd_len, req_ack, req_done, req_err, dma_abort, busy, owner, err_count. Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE
    - Any req_valid at cycle t: grant the first set bit searching from pointer+1, with wrap.
    - At t+1: owner = winner, pointer = winner, req_ack[winner] = 1, cmd_addr/cmd_len latched, busy = 1.
    - Next state is ISSUE, or ZERO if len==0.
  - ZERO
    - One cycle; req_err[owner] = 1, err_count+1, return to IDLE. No command is issued.
  - ISSUE
    - cmd_valid = 1; cmd_addr and cmd_len stay stable until cmd_ready.
    - On cmd_valid && cmd_ready: drop cmd_valid next cycle, clear the timeout counter, go to WAIT.
    - No timeout applies in ISSUE.
  - WAIT
    - Timeout counter increments each cycle.
    - dma_err: req_err[owner], err_count+1.
    - dma_done (without dma_err): req_done[owner].
    - Counter == TIMEOUT_CYC-1 with no done/err: dma_abort, req_err[owner], err_count+1.
    - All three exits take one cycle in DONE, then go to IDLE.
  - DONE
    - Output pulses are asserted here.
    - busy drops on the cycle IDLE is re-entered.
    - Arbitration resumes in IDLE, so the minimum spacing between two acks is ISSUE handshake + WAIT + 2 cycles.
- Simultaneous events:
  - dma_err and dma_done in the same cycle: treated as error.
  - done/err arriving in the same cycle the timeout fires: done/err wins, no dma_abort.
  - dma_done or dma_err outside WAIT: ignored.
- Fairness: a requester holding req_valid is granted within NUM_REQ arbitration rounds.
- Requests are sampled only in IDLE. A req_valid deasserted before ack is simply not granted. Dropping req_valid after ack has no effect.
- err_count saturates at 8'hFF.
- Reset mid-operation clears everything immediately. No pulse is emitted for the aborted transfer, and the DMA is not aborted by this block.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package dma_sched_pkg holds the state enum (IDLE, ZERO, ISSUE, WAIT, DONE), default widths, and the clog2 helper for owner width.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from req vector and pointer, returning grant index and any_req. The scheduler owns the pointer register.

Test Plan:
- Single request on requester 2, addr 0x8000_0000, len 0x400, cmd_ready=1, dma_done 10 cycles later:
  - req_ack[2] one cycle after req_valid;
  - cmd_addr=0x8000_0000, cmd_len=0x400;
  - req_done[2] pulse, busy back to 0, err_count=0.
- All four requesters hold req_valid for 8 transfers: grant order 0,1,2,3,0,1,2,3; each req_ack pulses exactly twice.
- cmd_ready held low 5 cycles: cmd_valid stays 1 and cmd_addr/cmd_len stay stable for 5 cycles; command accepted on the 6th.
- No dma_done after the handshake: dma_abort and req_err[owner] exactly TIMEOUT_CYC cycles into WAIT; err_count=1.
- Zero-length request on requester 1: req_ack[1], then req_err[1], cmd_valid never asserted, err_count increments.
- dma_done and dma_err in the same cycle: req_err only, no req_done.
- aresetn low in WAIT: all outputs 0 immediately; next request is granted starting from requester 0.
